mem_stage: RTL and testbench

Load/store unit for the pipelined RISC core. It sits directly after the execute stage and takes the ALU result as the effective address and rs2 data as store data. It drives a request/grant/response handshake to data memory, aligns and sign-extends load data, and stalls the pipeline until each access completes. It also flags misaligned or illegal accesses and memory timeouts.

---
 rtl/mem_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Load/store unit. Issues one data-memory access per load or
//                store instruction over a req/gnt/rvalid handshake, aligns and
//                extends load data, stalls the pipeline until the access ends,
//                and reports misaligned/illegal accesses and bus timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misaligned,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam int                 C_CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LIMIT = C_CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q,   state_d;
    logic                 we_q,      we_d;
    logic [1:0]           off_q,     off_d;
    logic [2:0]           func3_q,   func3_d;
    logic                 req_q,     req_d;
    logic [31:0]          daddr_q,   daddr_d;
    logic [3:0]           be_q,      be_d;
    logic [31:0]          wdata_q,   wdata_d;
    logic [C_CNT_W-1:0]   cnt_q,     cnt_d;
    logic                 tout_q,    tout_d;
    logic [31:0]          ldata_q,   ldata_d;
    logic                 mis_q,     mis_d;

    logic                 w_access;
    logic                 w_both;
    logic                 w_store;
    logic                 w_f3_bad;
    logic                 w_unaligned;
    logic                 w_fault;
    logic                 w_start;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_ext;

    // Decode the incoming instruction: legality, byte enables, lane-replicated store data
    always_comb begin
        w_access    = valid_in & (mem_read | mem_write);
        w_both      = mem_read & mem_write;
        w_store     = mem_write & ~mem_read;
        case (func3)
            3'b000, 3'b001, 3'b010: w_f3_bad = 1'b0;
            3'b100, 3'b101:         w_f3_bad = w_store;   // unsigned stores do not exist
            default:                w_f3_bad = 1'b1;
        endcase
        w_unaligned = ((func3[1:0] == 2'b01) & addr[0]) |
                      ((func3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
        w_fault     = w_access & (w_both | w_f3_bad | w_unaligned);
        w_start     = w_access & ~w_fault;
        case (func3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = wdata;
            end
        endcase
    end

    // Pick the addressed byte/half from the returned word and extend it
    always_comb begin
        case (off_q)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (func3_q)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = dmem_rdata;
        endcase
    end

    // Access sequencing: next state plus next values of every registered output
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        off_d   = off_q;
        func3_d = func3_q;
        req_d   = req_q;
        daddr_d = daddr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        tout_d  = tout_q;
        ldata_d = ldata_q;
        mis_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    off_d   = addr[1:0];
                    func3_d = func3;
                    daddr_d = {addr[31:2], 2'b00};
                    be_d    = w_be;
                    wdata_d = w_wdata;
                    cnt_d   = '0;
                    tout_d  = 1'b0;
                end else if (w_fault) begin
                    mis_d = 1'b1;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_gnt) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = S_DONE;
                    end else if (dmem_rvalid) begin
                        ldata_d = w_ext;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (cnt_q == C_CNT_LIMIT) begin
                    req_d   = 1'b0;
                    tout_d  = 1'b1;
                    ldata_d = '0;
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_rvalid) begin
                    ldata_d = w_ext;
                    state_d = S_DONE;
                end else if (cnt_q == C_CNT_LIMIT) begin
                    tout_d  = 1'b1;
                    ldata_d = '0;
                    state_d = S_DONE;
                end
            end
            default: begin
                // Finished instruction may still be on valid_in; it must not restart
                state_d = S_IDLE;
                tout_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            off_q   <= 2'd0;
            func3_q <= 3'd0;
            req_q   <= 1'b0;
            daddr_q <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
            ldata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            off_q   <= off_d;
            func3_q <= func3_d;
            req_q   <= req_d;
            daddr_q <= daddr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
            ldata_q <= ldata_d;
            mis_q   <= mis_d;
        end
    end

    assign stall      = ((state_q == S_IDLE) & w_start) | (state_q == S_REQ) | (state_q == S_WAIT);
    assign load_valid = (state_q == S_DONE) & ~we_q & ~tout_q;
    assign bus_err    = (state_q == S_DONE) & tout_q;
    assign load_data  = ldata_q;
    assign misaligned = mis_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = daddr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage. Directed cases followed by
//                randomized accesses compared against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, mem_read, mem_write;
    logic [2:0]  func3;
    logic [31:0] addr, wdata;
    logic        stall, load_valid, misaligned, bus_err;
    logic [31:0] load_data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_load;

    mem_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .func3      (func3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_gnt   (dmem_gnt),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One instruction through the stage. Memory grants gd cycles after the
    // request appears and returns data rd cycles after the grant.
    task automatic do_access(input bit v, input bit mr, input bit mw, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input int gd,
                             input int rd, input logic [31:0] rdat, input bit no_gnt,
                             input bit no_rv);
        bit          access, both, store, illegal, unal, fault, legal, timeout;
        int          nb, g, complete, done_c, req_end;
        logic [31:0] exp_be, exp_wd, exp_ld, mask, sh;
        // --- reference model ---
        access  = v && (mr || mw);
        both    = mr && mw;
        store   = mw && !mr;
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                  (store && (f3 == 3'b100 || f3 == 3'b101));
        nb      = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        unal    = (a % nb) != 0;
        fault   = access && (both || illegal || unal);
        legal   = access && !fault;
        exp_be  = ((32'd1 << nb) - 32'd1) << (a % 4);
        if (nb == 1)      exp_wd = (wd & 32'hFF) * 32'h01010101;
        else if (nb == 2) exp_wd = (wd & 32'hFFFF) * 32'h00010001;
        else              exp_wd = wd;
        sh = rdat >> (8 * (a % 4));
        if (nb == 4) exp_ld = rdat;
        else begin
            mask   = (32'd1 << (8 * nb)) - 32'd1;
            exp_ld = sh & mask;
            if (!f3[2] && exp_ld[8 * nb - 1]) exp_ld = exp_ld | ~mask;
        end
        g        = no_gnt ? 1000 : 1 + gd;
        complete = store ? g : (no_rv ? 1000 : g + rd);
        timeout  = complete > T + 1;
        done_c   = timeout ? T + 2 : complete + 1;
        req_end  = (g <= T + 1) ? g : T + 1;

        // --- start cycle ---
        @(negedge clk);
        valid_in = v; mem_read = mr; mem_write = mw; func3 = f3; addr = a; wdata = wd;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
        #1;
        check("start_stall", 32'(stall), 32'(legal));
        check("start_req", 32'(dmem_req), 32'd0);

        if (!legal) begin
            @(negedge clk);
            valid_in = 1'b0;
            #1;
            check("misaligned", 32'(misaligned), 32'(fault));
            check("fault_req", 32'(dmem_req), 32'd0);
            check("fault_stall", 32'(stall), 32'd0);
            return;
        end

        if (timeout)    last_load = 32'd0;
        else if (!store) last_load = exp_ld;

        // Instruction operands stay on the inputs while stalled, as the pipeline would hold them
        for (int c = 1; c <= done_c; c++) begin
            @(negedge clk);
            dmem_gnt    = (c == g);
            dmem_rvalid = !store && (c == complete);
            dmem_rdata  = (c == complete) ? rdat : $urandom;
            if (timeout && !store && c == done_c) dmem_rvalid = 1'b1;  // late reply into DONE
            #1;
            if (c == 1) check("no_mis", 32'(misaligned), 32'd0);
            if (c < done_c) begin
                check("req", 32'(dmem_req), 32'(c <= req_end));
                check("stall", 32'(stall), 32'd1);
                check("early_done", {30'd0, load_valid, bus_err}, 32'd0);
                if (c <= req_end) begin
                    check("addr", dmem_addr, a & ~32'h3);
                    check("be", 32'(dmem_be), exp_be);
                    check("we", 32'(dmem_we), 32'(store));
                    if (store) check("wdata", dmem_wdata, exp_wd);
                end
            end else begin
                check("done_req", 32'(dmem_req), 32'd0);
                check("done_stall", 32'(stall), 32'd0);
                check("load_valid", 32'(load_valid), 32'(!store && !timeout));
                check("bus_err", 32'(bus_err), 32'(timeout));
                check("load_data", load_data, last_load);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; func3 = 3'd0;
        addr = '0; wdata = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        last_load = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_flags", {29'd0, load_valid, misaligned, bus_err}, 32'd0);
        check("rst_bus", {dmem_addr[27:0], dmem_be}, 32'd0);
        rst = 1'b0;

        // lw with zero-wait memory
        do_access(1, 1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0);
        // lb, lbu at 0x103, lh at 0x102
        do_access(1, 1, 0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80FF0000, 0, 0);
        do_access(1, 1, 0, 3'b100, 32'h103, 32'h0, 1, 0, 32'h80FF0000, 0, 0);
        do_access(1, 1, 0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h80FF0000, 0, 0);
        // sh with grant delayed 3 cycles
        do_access(1, 0, 1, 3'b001, 32'h206, 32'h1234ABCD, 3, 0, 32'h0, 0, 0);
        // faults
        do_access(1, 1, 0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0, 0, 0);
        do_access(1, 0, 1, 3'b001, 32'h3,   32'h0, 0, 0, 32'h0, 0, 0);
        do_access(1, 1, 0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0, 0, 0);
        do_access(1, 1, 1, 3'b010, 32'h100, 32'h0, 0, 0, 32'h0, 0, 0);
        // lw after a value, so the timeout clearing load_data is visible
        do_access(1, 1, 0, 3'b010, 32'h44, 32'h0, 0, 0, 32'h13579BDF, 0, 0);
        // timeouts: granted but no data, then never granted
        do_access(1, 1, 0, 3'b010, 32'h40, 32'h0, 0, 0, 32'h0, 0, 1);
        do_access(1, 1, 0, 3'b000, 32'h41, 32'h0, 0, 0, 32'h0, 1, 1);

        // stray response in IDLE is ignored
        @(negedge clk);
        valid_in = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
        #1;
        check("stray_stall", 32'(stall), 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        check("stray_lvalid", 32'(load_valid), 32'd0);
        check("stray_data", load_data, 32'd0);
        check("stray_req", 32'(dmem_req), 32'd0);

        // randomized accesses
        for (int i = 0; i < 60; i++) begin
            bit          v, mr, mw;
            int          k;
            logic [2:0]  f3;
            logic [31:0] a;
            v  = ($urandom_range(0, 7) != 0);
            k  = $urandom_range(0, 10);
            mr = (k < 5) || (k == 9);
            mw = (k >= 5) && (k <= 9);
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_access(v, mr, mw, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                      $urandom, 0, 0);
        end

        // reset while waiting for read data
        @(negedge clk);
        valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; func3 = 3'b010; addr = 32'h400;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        @(negedge clk);
        dmem_gnt = 1'b1;
        #1;
        check("rw_req", 32'(dmem_req), 32'd1);
        @(negedge clk);
        dmem_gnt = 1'b0; valid_in = 1'b0;
        #1;
        check("rw_wait_stall", 32'(stall), 32'd1);
        check("rw_wait_req", 32'(dmem_req), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rw_rst_stall", 32'(stall), 32'd0);
        check("rw_rst_req", 32'(dmem_req), 32'd0);
        check("rw_rst_data", load_data, 32'd0);
        last_load = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rw_after_lvalid", 32'(load_valid), 32'd0);
        do_access(1, 1, 0, 3'b101, 32'h402, 32'h0, 1, 1, 32'h8001FFFF, 0, 0);
        do_access(1, 0, 1, 3'b000, 32'h501, 32'h000000A5, 0, 0, 32'h0, 0, 0);

        @(negedge clk);
        valid_in = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
